// File: rtl/botao_debounce.sv
// botao_debounce: synchronise, debounce and strobe an active-low push-button.
module botao_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_WIDTH = 32
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);
  localparam logic [1:0] RELEASED = 2'd0, PRESS_CONFIRM = 2'd1, HELD = 2'd2, RELEASE_CONFIRM = 2'd3;
  localparam logic [CNT_WIDTH-1:0] DEB = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DLY = CNT_WIDTH'(REPEAT_DELAY);
  localparam logic [CNT_WIDTH-1:0] PER_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic sync1_q, sync2_q, s, stay_held, armed, hold_hit, per_hit;
  logic [1:0] state_q, state_d;
  logic [CNT_WIDTH-1:0] db_q, db_d, hold_q, hold_d, per_q, per_d;
  logic pressed_d, press_d, release_d, repeat_d;
  always_comb begin
    s = ~sync2_q;
    stay_held = state_q == HELD && s;
    armed = stay_held && hold_q >= DLY;
    hold_d = stay_held ? (&hold_q ? hold_q : hold_q + ONE) : hold_q;
    hold_hit = stay_held && hold_q != DLY && hold_d == DLY;
    per_hit = armed && per_q == PER_LAST;
    per_d = hold_hit ? '0 : armed ? (per_hit ? '0 : per_q + ONE) : per_q;
    repeat_d = REPEAT_DELAY != 0 && (hold_hit || per_hit);
    state_d = state_q;
    db_d = db_q;
    press_d = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: if (s) begin
        state_d = PRESS_CONFIRM;
        db_d = ONE;
      end
      PRESS_CONFIRM: if (!s) begin
        state_d = RELEASED;
        db_d = '0;
      end else if (db_q == DEB) begin
        state_d = HELD;
        db_d = '0;
        press_d = 1'b1;
        hold_d = '0;
        per_d = '0;
      end else db_d = db_q + ONE;
      HELD: if (!s) begin
        state_d = RELEASE_CONFIRM;
        db_d = ONE;
      end
      default: if (s) begin
        state_d = HELD;
        db_d = '0;
      end else if (db_q == DEB) begin
        state_d = RELEASED;
        db_d = '0;
        release_d = 1'b1;
        hold_d = '0;
        per_d = '0;
      end else db_d = db_q + ONE;
    endcase
    pressed_d = state_d == HELD || state_d == RELEASE_CONFIRM;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RELEASED;
      db_q <= '0;
      hold_q <= '0;
      per_q <= '0;
      pressed <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      sync1_q <= botao;
      sync2_q <= sync1_q;
      state_q <= state_d;
      db_q <= db_d;
      hold_q <= hold_d;
      per_q <= per_d;
      pressed <= pressed_d;
      press_pulse <= press_d;
      release_pulse <= release_d;
      repeat_pulse <= repeat_d;
    end
  end
endmodule

// File: tb/tb_botao_debounce.sv
// tb_botao_debounce: scoreboard bench; expected strobes are queued as (cycle*10 + kind).
module tb_botao_debounce;
  localparam int DEB = 4, DLY = 10, PER = 3, LAT = DEB + 3;
  logic clock = 1'b0, reset_n = 1'b0, botao = 1'b1;
  logic pressed, press_pulse, release_pulse, repeat_pulse;
  logic nr_pressed, nr_press, nr_release, nr_repeat;
  int cyc = 0, n_chk = 0, n_pass = 0, nr_rep_cnt = 0, nr_press_cnt = 0, n_press_exp = 0;
  int q[$];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  botao_debounce #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .botao(botao), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse));
  botao_debounce #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(0), .REPEAT_PERIOD(PER), .CNT_WIDTH(16)) dut_nr (
    .clock(clock), .reset_n(reset_n), .botao(botao), .pressed(nr_pressed),
    .press_pulse(nr_press), .release_pulse(nr_release), .repeat_pulse(nr_repeat));
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic push(input int c, input int kind);
    q.push_back(c * 10 + kind);
    if (kind == 1) n_press_exp++;
  endtask
  // a single-cycle glitch driven at g pauses the hold count on edges g+3 and g+4
  task automatic push_repeats(input int p, input int lim, input int g);
    int c;
    for (int h = DLY; ; h += PER) begin
      c = (g < 0 || p + h <= g + 2) ? p + h : p + h + 2;
      if (c > lim) break;
      push(c, 3);
    end
  endtask
  task automatic mon(input int kind);
    if (q.size() == 0) chk("unexpected_pulse", cyc * 10 + kind, -1);
    else chk("pulse", cyc * 10 + kind, q.pop_front());
  endtask
  always @(negedge clock) begin
    if (press_pulse === 1'b1) mon(1);
    if (release_pulse === 1'b1) mon(2);
    if (repeat_pulse === 1'b1) mon(3);
    if (nr_repeat === 1'b1) nr_rep_cnt++;
    if (nr_press === 1'b1) nr_press_cnt++;
  end
  initial begin
    int c, p, rd, g, x, p2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset_outs", int'({pressed, press_pulse, release_pulse, repeat_pulse}), 0);
    end
    reset_n = 1'b1;
    tick(50);
    chk("idle_pressed", int'(pressed), 0);
    c = cyc; p = c + LAT; rd = p + 3;
    push(p, 1); push(rd + LAT, 2);
    botao = 1'b0;
    tick(LAT - 1); chk("press_lat_lo", int'(pressed), 0);
    tick(1); chk("press_lat_hi", int'(pressed), 1);
    tick(3);
    botao = 1'b1;
    tick(LAT - 1); chk("release_lat_hi", int'(pressed), 1);
    tick(1); chk("release_lat_lo", int'(pressed), 0);
    tick(10);
    botao = 1'b0; tick(3); botao = 1'b1; tick(1); botao = 1'b0; tick(2); botao = 1'b1;
    tick(20);
    chk("bounce_pressed", int'(pressed), 0);
    c = cyc; p = c + LAT;
    push(p, 1); push(p + 3 + LAT, 2);
    botao = 1'b0; tick(LAT + 3); botao = 1'b1; tick(LAT + 10);
    c = cyc; p = c + LAT; rd = p + 40;
    push(p, 1); push_repeats(p, rd + 2, -1); push(rd + LAT, 2);
    botao = 1'b0; tick(LAT + 40); botao = 1'b1; tick(LAT + 10);
    c = cyc; p = c + LAT; g = p + 11; rd = p + 25;
    push(p, 1); push_repeats(p, rd + 2, g); push(rd + LAT, 2);
    botao = 1'b0; tick(LAT + 11);
    botao = 1'b1; tick(1); botao = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("glitch_pressed", int'(pressed), 1);
    end
    tick(rd - cyc);
    botao = 1'b1; tick(LAT + 10);
    c = cyc; p = c + LAT;
    push(p, 1);
    botao = 1'b0; tick(LAT + 3);
    x = cyc; p2 = x + 8;
    push(p2, 1); push(p2 + 2 + LAT, 2);
    reset_n = 1'b0; tick(1);
    chk("rst_hold_outs", int'({pressed, press_pulse, release_pulse, repeat_pulse}), 0);
    reset_n = 1'b1;
    tick(p2 - cyc - 1); chk("repress_lo", int'(pressed), 0);
    tick(1); chk("repress_hi", int'(pressed), 1);
    tick(2); botao = 1'b1; tick(LAT + 10);
    chk("queue_empty", q.size(), 0);
    chk("norepeat_count", nr_rep_cnt, 0);
    chk("norepeat_press_count", nr_press_cnt, n_press_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/botao_debounce.md
Name: botao_debounce

Overview:
- Conditions the raw active-low push-button pin (`botao`) before any consumer logic sees it, e.g. the LED toggle counter or vending-machine coin/selection FSMs.
- Synchronises the pin, rejects contact bounce, and publishes a clean pressed level.
- Also publishes single-cycle press/release strobes and an optional auto-repeat strobe while the button is held.
- One instance per physical button.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 1.
- REPEAT_DELAY, 25000000, cycles in HELD before the first repeat_pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat_pulses; must be >= 1.
- CNT_WIDTH, 32, width of the internal debounce and hold counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- botao  input  1  raw button pin; asynchronous; 0 = pressed.
- pressed  output  1  debounced level; 1 = button held.
- press_pulse  output  1  one-cycle strobe on the accepted press.
- release_pulse  output  1  one-cycle strobe on the accepted release.
- repeat_pulse  output  1  one-cycle auto-repeat strobe while held.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - both synchroniser flops load 1 (released);
  - state=RELEASED, debounce counter=0, hold counter=0;
  - all outputs 0.
  - Reset has priority over every other event.
- Synchroniser:
  - two flops in series on botao;
  - internal sample s = NOT (second flop), so s=1 means pressed.
- States and transitions:
  - RELEASED, pressed=0:
    - s=1 -> PRESS_CONFIRM, debounce counter=1.
  - PRESS_CONFIRM, pressed=0:
    - s=0 -> RELEASED, counter=0 (glitch rejected, no strobe).
    - s=1 and counter=DEBOUNCE_CYCLES -> HELD; pressed=1 and press_pulse=1 for exactly this one cycle; hold counter=0.
    - otherwise counter+1.
  - HELD, pressed=1:
    - s=0 -> RELEASE_CONFIRM, counter=1.
    - Hold counter increments every cycle in HELD.
  - RELEASE_CONFIRM, pressed=1:
    - s=1 -> HELD, counter=0; hold counter resumes from its held value (it pauses in this state).
    - s=0 and counter=DEBOUNCE_CYCLES -> RELEASED; pressed=0 and release_pulse=1 for one cycle; hold counter=0.
    - otherwise counter+1.
- Latency:
  - With a clean edge on botao, pressed changes DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new pin level.
  - The +2 is the synchroniser.
  - press_pulse and release_pulse coincide with the pressed transition.
- Auto-repeat (only if REPEAT_DELAY>0, only in HELD):
  - repeat_pulse=1 for one cycle when the hold counter reaches REPEAT_DELAY.
  - Then again every REPEAT_PERIOD cycles (at REPEAT_DELAY + k*REPEAT_PERIOD, k>=1).
  - Never in the same cycle as press_pulse.
  - A pending repeat is not emitted in RELEASE_CONFIRM; it fires on the next qualifying count after returning to HELD.
- Counter width:
  - the hold counter saturates at its maximum, so no wrap-around re-triggers REPEAT_DELAY;
  - repeat timing uses a separate period counter that wraps at REPEAT_PERIOD.
- Boundaries:
  - DEBOUNCE_CYCLES=1: a single confirming sample suffices.
  - Pulses of length <= DEBOUNCE_CYCLES-1 after sync produce no output activity.
  - Reset asserted while held: outputs clear immediately with no release_pulse. If the pin is still low after reset deasserts, a fresh press is debounced and press_pulse fires again.
- Outputs are registered; no combinational path from botao to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset/idle: reset_n=0 for 3 cycles, botao=1 -> all outputs 0 throughout and after release of reset; botao held 1 for 50 cycles -> no activity.
- Clean press: botao 1->0 and held -> pressed rises and press_pulse=1 for exactly one cycle, 6 edges after the first low sample; release likewise -> release_pulse one cycle, pressed falls 6 edges later.
- Bounce rejection: botao low 3 cycles, high 1, low 2, high -> pressed, press_pulse and release_pulse stay 0. A then-sustained low press gives exactly one press_pulse.
- Auto-repeat: hold 40 cycles after pressed rises -> repeat_pulse at hold counts 10, 13, 16, 19, ... (10 pulses by count 37), never coincident with press_pulse. A parameter override REPEAT_DELAY=0 -> zero repeat_pulses.
- Release bounce while held: single-cycle high glitch during HELD -> pressed stays 1, no release_pulse, repeat cadence delayed by the paused cycles only.
- Reset mid-hold: reset_n=0 one cycle while pressed=1 with botao still 0 -> outputs 0 next cycle, no release_pulse; new press_pulse 6 edges after reset_n returns high.
